// File: rtl/par_acc_window.sv
// par_acc_window: windowed parallel accumulator. Each cycle it pipelines a
// popcount of data_in and sums it over win_len accepted samples.
// Ports: clk, rst (async high); start, win_len, sat_mode (sampled at start);
// en, data_in (sample stream); countval, overflow, busy, done (results).
module par_acc_window #(
  parameter int LANES    = 16,
  parameter int WIDTH    = 8,
  parameter int WIN_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIN_BITS-1:0] win_len,
  input  logic                sat_mode,
  input  logic                en,
  input  logic [LANES-1:0]    data_in,
  output logic [WIDTH-1:0]    countval,
  output logic                overflow,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t              state;
  state_t              next;
  logic                load;
  logic [CW-1:0]       pc_d;
  logic [CW-1:0]       pc_q;
  logic                pc_v;
  logic [WIN_BITS-1:0] remaining;
  logic                sat_mode_q;
  logic [WIDTH:0]      sum;

  always_comb begin
    pc_d = '0;
    for (int i = 0; i < LANES; i++) begin
      pc_d = pc_d + CW'(data_in[i]);
    end
  end

  // Sum is one bit wider than the accumulator so the carry flags overflow.
  assign sum = {1'b0, countval} + (WIDTH + 1)'(pc_q);

  always_comb begin
    next = state;
    load = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          next = RUN;
        end
      end
      RUN: begin
        if (en && remaining == WIN_BITS'(1)) begin
          next = DRAIN;
        end
      end
      DRAIN: begin
        next = DONE;
      end
      DONE: begin
        if (start) begin
          load = 1'b1;
          next = RUN;
        end else begin
          next = IDLE;
        end
      end
      default: begin
        next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pc_q       <= '0;
      pc_v       <= 1'b0;
      remaining  <= '0;
      sat_mode_q <= 1'b0;
      countval   <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= next;
      busy  <= (next == RUN) || (next == DRAIN);
      done  <= (next == DONE);
      pc_q  <= pc_d;
      pc_v  <= en && (state == RUN);
      if (load) begin
        remaining  <= (win_len == '0) ? WIN_BITS'(1) : win_len;
        sat_mode_q <= sat_mode;
        countval   <= '0;
        overflow   <= 1'b0;
      end else begin
        if (state == RUN && en) begin
          remaining <= remaining - WIN_BITS'(1);
        end
        if (pc_v) begin
          if (sum[WIDTH]) begin
            overflow <= 1'b1;
            countval <= sat_mode_q ? '1 : sum[WIDTH-1:0];
          end else begin
            countval <= sum[WIDTH-1:0];
          end
        end
      end
    end
  end

endmodule
